// File: rtl/ps2_steer_decoder_pkg.sv
// Scancodes, decoder states and held-bit layout shared by the PS/2 steering decoder.
package ps2_steer_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam int unsigned HELD_W     = 6;
  localparam int unsigned IDX_W      = 0;
  localparam int unsigned IDX_A      = 1;
  localparam int unsigned IDX_D      = 2;
  localparam int unsigned IDX_UP     = 3;
  localparam int unsigned IDX_LEFT   = 4;
  localparam int unsigned IDX_RIGHT  = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } state_t;

  // One-hot held-bit mask for a plain scancode; zero when unmapped.
  function automatic logic [HELD_W-1:0] plain_mask(input logic [7:0] code);
    logic [HELD_W-1:0] m;
    m = '0;
    case (code)
      SC_W:    m[IDX_W] = 1'b1;
      SC_A:    m[IDX_A] = 1'b1;
      SC_D:    m[IDX_D] = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

  function automatic logic [HELD_W-1:0] ext_mask(input logic [7:0] code);
    logic [HELD_W-1:0] m;
    m = '0;
    case (code)
      SC_UP:    m[IDX_UP]    = 1'b1;
      SC_LEFT:  m[IDX_LEFT]  = 1'b1;
      SC_RIGHT: m[IDX_RIGHT] = 1'b1;
      default:  m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_steer_decoder_if.sv
// Byte-in / steering-out bundle between the PS/2 receiver, the decoder and projectTop.
interface ps2_steer_decoder_if;
  logic [7:0] ps2Byte;
  logic       ps2ByteValid;
  logic       moveForward;
  logic       moveLeft;
  logic       moveRight;
  logic       keyEvent;

  modport master (
    output ps2Byte, ps2ByteValid,
    input  moveForward, moveLeft, moveRight, keyEvent
  );

  modport slave (
    input  ps2Byte, ps2ByteValid,
    output moveForward, moveLeft, moveRight, keyEvent
  );
endinterface

// File: rtl/ps2_steer_decoder.sv
// Tracks PS/2 make/break (incl. E0 prefix) for W/A/D and arrows into held steering levels.
module ps2_steer_decoder
  import ps2_steer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input logic               Clock,
  input logic               Reset,
  input logic               Start,
  ps2_steer_decoder_if.slave bus
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t            state, state_next;
  logic [CW-1:0]     cnt, cnt_next;
  logic [HELD_W-1:0] held, held_next;
  logic              fwd_any, left_any, right_any;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    held_next  = held;
    if (bus.ps2ByteValid) begin
      cnt_next = '0;
      case (state)
        ST_IDLE: begin
          if (bus.ps2Byte == SC_EXT)      state_next = ST_EXT;
          else if (bus.ps2Byte == SC_BRK) state_next = ST_BRK;
          else                            held_next  = held | plain_mask(bus.ps2Byte);
        end
        ST_EXT: begin
          if (bus.ps2Byte == SC_BRK) begin
            state_next = ST_EXT_BRK;
          end else begin
            held_next  = held | ext_mask(bus.ps2Byte);
            state_next = ST_IDLE;
          end
        end
        ST_BRK: begin
          held_next  = held & ~plain_mask(bus.ps2Byte);
          state_next = ST_IDLE;
        end
        default: begin
          held_next  = held & ~ext_mask(bus.ps2Byte);
          state_next = ST_IDLE;
        end
      endcase
    end else if (state != ST_IDLE) begin
      // A byte in the expiry cycle wins, so the timeout is only taken here.
      if (cnt == CNT_LAST) begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
  end

  assign fwd_any   = held_next[IDX_W] | held_next[IDX_UP];
  assign left_any  = held_next[IDX_A] | held_next[IDX_LEFT];
  assign right_any = held_next[IDX_D] | held_next[IDX_RIGHT];

  always_ff @(posedge Clock) begin
    if (Reset || !Start) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      held            <= '0;
      bus.moveForward <= 1'b0;
      bus.moveLeft    <= 1'b0;
      bus.moveRight   <= 1'b0;
      bus.keyEvent    <= 1'b0;
    end else begin
      state           <= state_next;
      cnt             <= cnt_next;
      held            <= held_next;
      bus.moveForward <= fwd_any;
      bus.moveLeft    <= left_any & ~right_any;
      bus.moveRight   <= right_any & ~left_any;
      bus.keyEvent    <= (held_next != held);
    end
  end

endmodule

// File: tb/tb_ps2_steer_decoder.sv
// Directed-vector bench for ps2_steer_decoder with hand-computed expectations.
module tb_ps2_steer_decoder;

  localparam int unsigned TO = 16;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic Start = 1'b1;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned ev_cnt   = 0;
  int unsigned ev_base  = 0;

  ps2_steer_decoder_if bus ();

  ps2_steer_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Start (Start),
    .bus   (bus.slave)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) if (bus.keyEvent) ev_cnt <= ev_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // {moveForward, moveLeft, moveRight}
  function automatic logic [31:0] outs();
    return {29'd0, bus.moveForward, bus.moveLeft, bus.moveRight};
  endfunction

  task automatic send(input logic [7:0] b);
    bus.ps2Byte      = b;
    bus.ps2ByteValid = 1'b1;
    @(posedge Clock);
    #1;
    bus.ps2ByteValid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  initial begin
    bus.ps2Byte      = 8'h00;
    bus.ps2ByteValid = 1'b0;
    idle(3);
    check("reset_outs", outs(), 32'd0);
    check("reset_event", {31'd0, bus.keyEvent}, 32'd0);
    Reset = 1'b0;

    send(8'h1D);
    check("w_make", outs(), 32'b100);
    check("w_make_event", {31'd0, bus.keyEvent}, 32'd1);
    send(8'hF0);
    check("brk_prefix_event", {31'd0, bus.keyEvent}, 32'd0);
    check("brk_prefix_hold", outs(), 32'b100);
    send(8'h1D);
    check("w_break", outs(), 32'b000);
    check("w_break_event", {31'd0, bus.keyEvent}, 32'd1);

    send(8'hE0); send(8'h6B);
    check("left_arrow", outs(), 32'b010);
    send(8'h23);
    check("left_and_d", outs(), 32'b000);
    send(8'hE0); send(8'hF0); send(8'h6B);
    check("left_release", outs(), 32'b001);
    send(8'hF0); send(8'h23);
    check("d_release", outs(), 32'b000);

    send(8'h1D); send(8'hE0); send(8'h75);
    send(8'hF0); send(8'h1D);
    check("up_still_held", outs(), 32'b100);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("up_release", outs(), 32'b000);

    send(8'hF0);
    idle(TO);
    send(8'h1C);
    check("timeout_make", outs(), 32'b010);
    send(8'hF0);
    idle(TO - 1);
    send(8'h1C);
    check("timeout_same_cycle_brk", outs(), 32'b000);
    send(8'hE0);
    idle(TO - 2);
    send(8'h74);
    check("ext_before_timeout", outs(), 32'b001);
    send(8'hE0); send(8'hF0); send(8'h74);
    check("right_release", outs(), 32'b000);

    send(8'h1D);
    idle(2);
    ev_base = ev_cnt;
    Start = 1'b0;
    idle(1);
    check("start_low_outs", outs(), 32'd0);
    send(8'h1D);
    send(8'h1C);
    idle(1);
    check("start_low_ignored", outs(), 32'd0);
    check("start_low_no_event", ev_cnt - ev_base, 32'd0);
    Start = 1'b1;
    send(8'h1D);
    check("start_resume", outs(), 32'b100);
    check("start_resume_event", {31'd0, bus.keyEvent}, 32'd1);
    send(8'hF0); send(8'h1D);

    send(8'hE0);
    Reset = 1'b1;
    idle(1);
    Reset = 1'b0;
    send(8'h74);
    check("reset_mid_ext", outs(), 32'd0);
    check("reset_mid_event", {31'd0, bus.keyEvent}, 32'd0);

    idle(1);
    ev_base = ev_cnt;
    send(8'h1D); send(8'h1D); send(8'h1D);
    idle(2);
    check("typematic_outs", outs(), 32'b100);
    check("typematic_one_event", ev_cnt - ev_base, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
